uart_rx_frame_chk: RTL

Parametrised UART receive frame checker for the UART RX path. It consumes mid-bit samples from the oversampling/sampler stage and walks a full frame: start, DATA_WIDTH data bits, optional parity, then 1 or 2 stop bits. It de-serialises the data and flags start glitches, parity errors and stop (framing) errors. It also keeps a saturating count of errored frames for the register block.

---
 rtl/uart_rx_frame_chk.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: walks a UART frame from mid-bit samples, de-serialises data
// and flags start glitches, parity and stop errors with a saturating error count.
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  two_stop,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx, data_out_nx;
  logic [ERR_CNT_W-1:0] err_cnt_nx;
  logic xacc, xacc_nx, sh_par_en, sh_par_en_nx, sh_par_typ, sh_par_typ_nx;
  logic sh_two_stop, sh_two_stop_nx, strt_glitch_nx, par_err_nx, stp_err_nx;
  logic busy_nx, data_valid_nx, frame_done_nx, fin, err_inc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      xacc        <= 1'b0;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= 1'b0;
      sh_two_stop <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      shreg       <= shreg_nx;
      xacc        <= xacc_nx;
      sh_par_en   <= sh_par_en_nx;
      sh_par_typ  <= sh_par_typ_nx;
      sh_two_stop <= sh_two_stop_nx;
      busy        <= busy_nx;
      data_out    <= data_out_nx;
      data_valid  <= data_valid_nx;
      frame_done  <= frame_done_nx;
      strt_glitch <= strt_glitch_nx;
      par_err     <= par_err_nx;
      stp_err     <= stp_err_nx;
      err_cnt     <= err_cnt_nx;
    end
  end
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    shreg_nx       = shreg;
    xacc_nx        = xacc;
    sh_par_en_nx   = sh_par_en;
    sh_par_typ_nx  = sh_par_typ;
    sh_two_stop_nx = sh_two_stop;
    data_out_nx    = data_out;
    strt_glitch_nx = strt_glitch;
    par_err_nx     = par_err;
    stp_err_nx     = stp_err;
    data_valid_nx  = 1'b0;
    frame_done_nx  = 1'b0;
    fin            = 1'b0;
    err_inc        = 1'b0;
    case (state)
      IDLE: if (frame_start && !frame_done) begin
        // frame_done high means the previous frame is still retiring
        state_nx       = START;
        strt_glitch_nx = 1'b0;
        par_err_nx     = 1'b0;
        stp_err_nx     = 1'b0;
        sh_par_en_nx   = par_en;
        sh_par_typ_nx  = par_typ;
        sh_two_stop_nx = two_stop;
      end
      START: if (bit_valid) begin
        state_nx       = sampled_bit ? IDLE : DATA;
        strt_glitch_nx = sampled_bit;
        frame_done_nx  = sampled_bit;
        err_inc        = sampled_bit;
        cnt_nx         = '0;
        xacc_nx        = 1'b0;
      end
      DATA: if (bit_valid) begin
        shreg_nx = {sampled_bit, shreg[DATA_WIDTH-1:1]};
        xacc_nx  = xacc ^ sampled_bit;
        cnt_nx   = cnt + 1'b1;
        if (cnt == CW'(DATA_WIDTH - 1)) state_nx = sh_par_en ? PARITY : STOP1;
      end
      PARITY: if (bit_valid) begin
        par_err_nx = (xacc ^ sampled_bit) != sh_par_typ;
        state_nx   = STOP1;
      end
      STOP1: if (bit_valid) begin
        stp_err_nx = !sampled_bit;
        fin        = !sampled_bit || !sh_two_stop;
        state_nx   = fin ? IDLE : STOP2;
      end
      STOP2: if (bit_valid) begin
        stp_err_nx = !sampled_bit;
        fin        = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (fin) begin
      frame_done_nx = 1'b1;
      err_inc       = par_err_nx || stp_err_nx;
      data_valid_nx = !err_inc;
      data_out_nx   = err_inc ? data_out : shreg;
    end
    err_cnt_nx = (err_inc && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    busy_nx    = state_nx != IDLE;
  end
endmodule
